// File: rtl/ntt_pkg.sv
// Shared defaults and FSM encoding for the in-place Cooley-Tukey NTT controller.
package ntt_pkg;

  localparam int N_DEF        = 256;
  localparam int LOGN_DEF     = 8;
  localparam int PIPE_LAT_DEF = 9;
  localparam int Q            = 12289;
  localparam int DATA_W       = 14;

  // state   | meaning
  // IDLE    | waiting for start
  // RUN     | issuing two butterflies per cycle for the current stage
  // DRAIN   | butterfly pipe emptying before the next stage reads
  // DONE    | one-cycle completion pulse
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef logic [DATA_W-1:0] coeff_t;

endpackage

// File: rtl/delay_line.sv
// Register chain with synchronous clear; realigns read-side strobes and addresses
// to the write-back side of the butterfly pipeline.
module delay_line
  import ntt_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_addr_ctrl.sv
// NTT stage/cycle sequencer: two butterflies per issue cycle, read/twiddle addresses
// registered from next-state so they line up with rd_en, write-back via delay_line.
module ntt_addr_ctrl
  import ntt_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOGN     = LOGN_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a0,
  output logic [LOGN-1:0] rd_addr_b0,
  output logic [LOGN-1:0] rd_addr_a1,
  output logic [LOGN-1:0] rd_addr_b1,
  output logic [LOGN-1:0] tw_addr0,
  output logic [LOGN-1:0] tw_addr1,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a0,
  output logic [LOGN-1:0] wr_addr_b0,
  output logic [LOGN-1:0] wr_addr_a1,
  output logic [LOGN-1:0] wr_addr_b1
);

  localparam int CW = LOGN - 2;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int LW = 4*LOGN + 1;
  localparam logic [CW-1:0]   C_LAST     = CW'(N/4 - 1);
  localparam logic [LOGN-1:0] S_LAST     = LOGN'(LOGN - 1);
  localparam logic [LOGN-1:0] ONE        = LOGN'(1);
  localparam logic [DW-1:0]   DRAIN_INIT = DW'(PIPE_LAT - 1);

  logic [1:0]      state_q, state_d;
  logic [LOGN-1:0] s_q, s_d;
  logic [CW-1:0]   c_q, c_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic            rd_en_q, rd_en_d;
  logic [LOGN-1:0] a0_q, b0_q, a1_q, b1_q, tw0_q, tw1_q;
  logic [LOGN-1:0] a0_d, b0_d, a1_d, b1_d, tw0_d, tw1_d;
  logic [3*LOGN-1:0] bu0, bu1;

  // half-span h = 1<<sh, group g = j>>sh; top = g*2h + k built from shifts only
  function automatic logic [3*LOGN-1:0] bfly(input logic [LOGN-1:0] s,
                                             input logic [LOGN-1:0] j);
    logic [LOGN-1:0] sh, h, g, k, top;
    sh  = S_LAST - s;
    h   = ONE << sh;
    g   = j >> sh;
    k   = j & (h - ONE);
    top = ((g << sh) << 1) | k;
    return {top, top | h, (ONE << s) + g};
  endfunction

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    dly_d   = dly_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        s_d     = '0;
        c_d     = '0;
      end
      ST_RUN: if (c_q == C_LAST) begin
        state_d = ST_DRAIN;
        c_d     = '0;
        dly_d   = DRAIN_INIT;
      end else begin
        c_d = c_q + 1'b1;
      end
      ST_DRAIN: if (dly_q == '0) begin
        if (s_q == S_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
          s_d     = s_q + 1'b1;
        end
      end else begin
        dly_d = dly_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bu0 = bfly(s_d, {1'b0, c_d, 1'b0});
  assign bu1 = bfly(s_d, {1'b0, c_d, 1'b1});

  always_comb begin
    rd_en_d = (state_d == ST_RUN);
    {a0_d, b0_d, tw0_d} = '0;
    {a1_d, b1_d, tw1_d} = '0;
    if (rd_en_d) begin
      {a0_d, b0_d, tw0_d} = bu0;
      {a1_d, b1_d, tw1_d} = bu1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      c_q     <= '0;
      dly_q   <= '0;
      rd_en_q <= 1'b0;
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      tw0_q   <= '0;
      tw1_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      dly_q   <= dly_d;
      rd_en_q <= rd_en_d;
      a0_q    <= a0_d;
      b0_q    <= b0_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      tw0_q   <= tw0_d;
      tw1_q   <= tw1_d;
    end
  end

  delay_line #(.WIDTH(LW), .DEPTH(PIPE_LAT)) u_wb_dly (
    .clk    (clk),
    .rstn   (rstn),
    .din_i  ({rd_en_q, a0_q, b0_q, a1_q, b1_q}),
    .dout_o ({wr_en, wr_addr_a0, wr_addr_b0, wr_addr_a1, wr_addr_b1})
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign rd_en      = rd_en_q;
  assign rd_addr_a0 = a0_q;
  assign rd_addr_b0 = b0_q;
  assign rd_addr_a1 = a1_q;
  assign rd_addr_b1 = b1_q;
  assign tw_addr0   = tw0_q;
  assign tw_addr1   = tw1_q;

endmodule
